// File: rtl/bcd_conv_scheduler.sv
// bcd_conv_scheduler: round-robin time-shared double-dabble binary-to-BCD engine for three channels.
// Optional BCD_CONV_SIGNED_EN: two's-complement operands converted as magnitude with a Neg flag.
module bcd_conv_scheduler #(
   parameter int W      = 32,
   parameter int DIGITS = 6
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   input  logic [2:0]            Req,
   input  logic [W-1:0]          Bin0,
   input  logic [W-1:0]          Bin1,
   input  logic [W-1:0]          Bin2,
   output logic [2:0]            Ack,
   output logic [2:0]            Done,
   output logic [4*DIGITS-1:0]   Bcd0,
   output logic [4*DIGITS-1:0]   Bcd1,
   output logic [4*DIGITS-1:0]   Bcd2,
   output logic [2:0]            Ovf,
   output logic [2:0]            Neg,
   output logic                  Busy
);
   localparam int BW = 4*DIGITS;
   localparam int CW = $clog2(W+1);
   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SHIFT = 1'b1;
   logic [0:0]    state_q, state_d;
   logic [1:0]    ptr_q, ptr_d, g_q, g_d;
   logic [W-1:0]  opnd_q, opnd_d;
   logic [BW-1:0] scr_q, scr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sticky_q, sticky_d;
   logic [2:0]    ack_q, ack_d, done_q, done_d, ovf_q, ovf_d;
   logic [BW-1:0] bcd_q [3];
   logic [BW-1:0] bcd_d [3];
   logic [1:0]    c1, c2, g;
   logic [W-1:0]  sel_bin, mag;
   logic [BW-1:0] adj, shifted;
   logic          fin;
   always_comb begin
      c1 = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
      c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
      g = Req[c1] ? c1 : Req[c2] ? c2 : ptr_q;
      sel_bin = (g == 2'd0) ? Bin0 : (g == 2'd1) ? Bin1 : Bin2;
      for (int k = 0; k < DIGITS; k++)
         adj[4*k +: 4] = (scr_q[4*k +: 4] >= 4'd5) ? scr_q[4*k +: 4] + 4'd3 : scr_q[4*k +: 4];
      shifted = {adj[BW-2:0], opnd_q[W-1]};
      fin = (state_q == S_SHIFT) && (cnt_q == CW'(1));
   end
`ifdef BCD_CONV_SIGNED_EN
   logic       neg_pend_q, neg_pend_d;
   logic [2:0] neg_q, neg_d;
   always_comb begin
      mag = sel_bin[W-1] ? ~sel_bin + 1'b1 : sel_bin;
      neg_pend_d = (state_q == S_IDLE && |Req) ? sel_bin[W-1] : neg_pend_q;
      neg_d = neg_q;
      if (fin) neg_d[g_q] = neg_pend_q;
   end
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         neg_pend_q <= 1'b0;
         neg_q <= '0;
      end else begin
         neg_pend_q <= neg_pend_d;
         neg_q <= neg_d;
      end
   end
   assign Neg = neg_q;
`else
   assign mag = sel_bin;
   assign Neg = '0;
`endif
   always_comb begin
      state_d = state_q;
      ptr_d = ptr_q;
      g_d = g_q;
      opnd_d = opnd_q;
      scr_d = scr_q;
      cnt_d = cnt_q;
      sticky_d = sticky_q;
      ack_d = '0;
      done_d = '0;
      ovf_d = ovf_q;
      bcd_d = bcd_q;
      if (state_q == S_IDLE) begin
         if (|Req) begin
            state_d = S_SHIFT;
            g_d = g;
            opnd_d = mag;
            scr_d = '0;
            cnt_d = CW'(W);
            sticky_d = 1'b0;
            ack_d[g] = 1'b1;
         end
      end else begin
         // top-digit carry-out is the 10^DIGITS wrap, so scratch stays value mod 10^DIGITS
         opnd_d = opnd_q << 1;
         scr_d = shifted;
         sticky_d = sticky_q | adj[BW-1];
         cnt_d = cnt_q - 1'b1;
         if (fin) begin
            state_d = S_IDLE;
            ptr_d = g_q;
            done_d[g_q] = 1'b1;
            ovf_d[g_q] = sticky_q | adj[BW-1];
            bcd_d[g_q] = shifted;
         end
      end
   end
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= S_IDLE;
         ptr_q <= 2'd2;
         g_q <= 2'd0;
         opnd_q <= '0;
         scr_q <= '0;
         cnt_q <= '0;
         sticky_q <= 1'b0;
         ack_q <= '0;
         done_q <= '0;
         ovf_q <= '0;
         bcd_q <= '{default: '0};
      end else begin
         state_q <= state_d;
         ptr_q <= ptr_d;
         g_q <= g_d;
         opnd_q <= opnd_d;
         scr_q <= scr_d;
         cnt_q <= cnt_d;
         sticky_q <= sticky_d;
         ack_q <= ack_d;
         done_q <= done_d;
         ovf_q <= ovf_d;
         bcd_q <= bcd_d;
      end
   end
   assign Ack = ack_q;
   assign Done = done_q;
   assign Ovf = ovf_q;
   assign Busy = (state_q == S_SHIFT);
   assign Bcd0 = bcd_q[0];
   assign Bcd1 = bcd_q[1];
   assign Bcd2 = bcd_q[2];
endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// tb_bcd_conv_scheduler: random + directed stimulus, decimal reference model and a Done-driven scoreboard.
module tb_bcd_conv_scheduler;
   localparam int W = 32;
`ifdef BCD_CONV_SIGNED_EN
   localparam bit SIGNED = 1'b1;
`else
   localparam bit SIGNED = 1'b0;
`endif
   logic        Clk = 1'b0, Rst_n = 1'b0;
   logic [2:0]  Req = '0;
   logic [31:0] Bin0 = '0, Bin1 = '0, Bin2 = '0;
   logic [2:0]  Ack, Done, Ovf, Neg;
   logic [23:0] Bcd0, Bcd1, Bcd2;
   logic        Busy;
   bcd_conv_scheduler #(.W(W), .DIGITS(6)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Bin0(Bin0), .Bin1(Bin1), .Bin2(Bin2),
      .Ack(Ack), .Done(Done), .Bcd0(Bcd0), .Bcd1(Bcd1), .Bcd2(Bcd2),
      .Ovf(Ovf), .Neg(Neg), .Busy(Busy)
   );
   always #5 Clk = ~Clk;
   typedef struct {
      int          ch;
      logic [23:0] bcd;
      logic        ovf;
      logic        neg;
   } exp_t;
   exp_t        q[$];
   logic [23:0] sh_bcd [3];
   logic        sh_ovf [3];
   logic        sh_neg [3];
   int          ptr = 2;
   int          checks = 0, failures = 0;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask
   function automatic exp_t model(input int ch, input logic [31:0] b);
      exp_t e;
      longint unsigned v;
      e.ch = ch;
      e.neg = SIGNED && b[31];
      v = e.neg ? (64'h1_0000_0000 - {32'd0, b}) : {32'd0, b};
      e.ovf = v > 999999;
      v = v % 1000000;
      e.bcd = '0;
      for (int k = 0; k < 6; k++) begin
         e.bcd[4*k +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return e;
   endfunction
   function automatic logic [31:0] rnd_bin();
      case ($urandom_range(0, 6))
         0: return 32'd999999;
         1: return 32'd1000000;
         2: return 32'h8000_0000;
         3: return 32'hFFFF_FFFF;
         4: return 32'($urandom_range(0, 999999));
         default: return $urandom;
      endcase
   endfunction
   always @(negedge Clk) begin
      if (Rst_n && |Done) begin
         chk("ack_done_excl", {61'd0, Ack}, 64'd0);
         if (q.size() == 0) chk("unexpected_done", {61'd0, Done}, 64'd0);
         else begin
            exp_t e;
            e = q.pop_front();
            chk("done_ch", {61'd0, Done}, 64'd1 << e.ch);
            sh_bcd[e.ch] = e.bcd;
            sh_ovf[e.ch] = e.ovf;
            sh_neg[e.ch] = e.neg;
            chk("bcd0", {40'd0, Bcd0}, {40'd0, sh_bcd[0]});
            chk("bcd1", {40'd0, Bcd1}, {40'd0, sh_bcd[1]});
            chk("bcd2", {40'd0, Bcd2}, {40'd0, sh_bcd[2]});
            chk("ovf", {61'd0, Ovf}, {61'd0, sh_ovf[2], sh_ovf[1], sh_ovf[0]});
            chk("neg", {61'd0, Neg}, {61'd0, sh_neg[2], sh_neg[1], sh_neg[0]});
         end
      end
   end
   // called just after a falling edge; inputs are sampled at the next rising edge
   task automatic do_txn(input logic [2:0] r, input logic [31:0] b0, b1, b2);
      int g, lat;
      logic [31:0] bs;
      Req = r;
      Bin0 = b0;
      Bin1 = b1;
      Bin2 = b2;
      if (r == 3'b000) begin
         repeat (3) @(negedge Clk);
         chk("idle_busy", {63'd0, Busy}, 64'd0);
         chk("idle_ack", {61'd0, Ack}, 64'd0);
         return;
      end
      g = -1;
      for (int k = 1; k <= 3; k++)
         if (g < 0 && r[(ptr + k) % 3]) g = (ptr + k) % 3;
      bs = (g == 0) ? b0 : (g == 1) ? b1 : b2;
      q.push_back(model(g, bs));
      @(negedge Clk);
      chk("ack", {61'd0, Ack}, 64'd1 << g);
      chk("busy", {63'd0, Busy}, 64'd1);
      Req = 3'($urandom_range(0, 7));
      Bin0 = $urandom;
      Bin1 = $urandom;
      Bin2 = $urandom;
      lat = 0;
      for (int i = 1; i <= W + 5; i++) begin
         @(negedge Clk);
         if (i == 1) chk("ack_pulse", {61'd0, Ack}, 64'd0);
         if (|Done) begin
            lat = i;
            break;
         end
      end
      chk("done_latency", 64'(lat), 64'(W));
      chk("busy_end", {63'd0, Busy}, 64'd0);
      ptr = g;
   endtask
   task automatic check_cleared(input string tag);
      chk({tag, "_ack"}, {61'd0, Ack}, 64'd0);
      chk({tag, "_done"}, {61'd0, Done}, 64'd0);
      chk({tag, "_bcd0"}, {40'd0, Bcd0}, 64'd0);
      chk({tag, "_bcd1"}, {40'd0, Bcd1}, 64'd0);
      chk({tag, "_bcd2"}, {40'd0, Bcd2}, 64'd0);
      chk({tag, "_ovf"}, {61'd0, Ovf}, 64'd0);
      chk({tag, "_neg"}, {61'd0, Neg}, 64'd0);
      chk({tag, "_busy"}, {63'd0, Busy}, 64'd0);
   endtask
   initial begin
      for (int c = 0; c < 3; c++) begin
         sh_bcd[c] = '0;
         sh_ovf[c] = 1'b0;
         sh_neg[c] = 1'b0;
      end
      #22;
      check_cleared("reset");
      @(negedge Clk);
      Rst_n = 1'b1;
      repeat (5) @(negedge Clk);
      chk("post_reset_busy", {63'd0, Busy}, 64'd0);
      do_txn(3'b001, 32'd123456, 32'd0, 32'd0);
      repeat (4) do_txn(3'b111, 32'd7, 32'd1013, 32'd45);
      do_txn(3'b001, 32'd1234567, 32'd0, 32'd0);
      do_txn(3'b001, 32'd999999, 32'd0, 32'd0);
      do_txn(3'b001, 32'hFFFF_F6D7, 32'd0, 32'd0);
      do_txn(3'b100, 32'd0, 32'd0, 32'd1000000);
      do_txn(3'b010, 32'd0, 32'h8000_0000, 32'd0);
      Req = 3'b010;
      Bin1 = 32'd424242;
      @(negedge Clk);
      chk("abort_ack", {61'd0, Ack}, 64'd2);
      repeat (9) @(negedge Clk);
      #2 Rst_n = 1'b0;
      #1 check_cleared("abort");
      q.delete();
      for (int c = 0; c < 3; c++) begin
         sh_bcd[c] = '0;
         sh_ovf[c] = 1'b0;
         sh_neg[c] = 1'b0;
      end
      ptr = 2;
      repeat (2) @(negedge Clk);
      Rst_n = 1'b1;
      do_txn(3'b010, 32'd0, 32'd654321, 32'd0);
      for (int n = 0; n < 40; n++)
         do_txn(3'($urandom_range(0, 7)), rnd_bin(), rnd_bin(), rnd_bin());
      repeat (2) @(negedge Clk);
      chk("queue_empty", 64'(q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
